// File: rtl/buffer_bitstream_gen_if.sv
// Handshake/data bundle between load buffer, controller and bitstream array.
// start/clear/iData flow into the generator; oBit/oValid/busy/done flow out.
interface buffer_bitstream_gen_if #(
    parameter int IWID = 8,
    parameter int IDIM = 4
);
    logic                       start;
    logic                       clear;
    logic [IDIM-1:0][IWID-1:0]  iData;
    logic [IDIM-1:0]            oBit;
    logic                       oValid;
    logic                       busy;
    logic                       done;

    modport master (
        output start, clear, iData,
        input  oBit, oValid, busy, done
    );

    modport slave (
        input  start, clear, iData,
        output oBit, oValid, busy, done
    );
endinterface

// File: rtl/buffer_bitstream_gen.sv
// Unipolar stochastic bitstream array: captures IDIM words, emits 2^IWID bits.
// Ports: clk, rst_n (async low), bus (slave: start/clear/iData in, oBit/oValid/busy/done out).
module buffer_bitstream_gen #(
    parameter int IWID = 8,
    parameter int IDIM = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    buffer_bitstream_gen_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                     state_q;
    state_t                     state_d;
    logic [IWID-1:0]            cnt_q;
    logic [IWID-1:0]            cnt_d;
    logic [IDIM-1:0][IWID-1:0]  data_q;
    logic [IDIM-1:0][IWID-1:0]  data_d;

    logic [IWID-1:0]            rng;
    logic [IDIM-1:0]            bit_c;
    logic                       valid_c;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    data_d  = bus.iData;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                // wraps to 0 on the final cycle
                cnt_d = cnt_q + 1'b1;
                if (&cnt_q) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // abort wins over everything, captured data is kept
        if (bus.clear) begin
            state_d = IDLE;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
        end
    end

    // bit-reversed counter is a low-discrepancy permutation of 0..2^IWID-1,
    // so each lane's 1-count over a full run equals its value exactly
    always_comb begin
        rng = '0;
        for (int k = 0; k < IWID; k++) begin
            rng[k] = cnt_q[IWID-1-k];
        end
    end

    assign valid_c = (state_q == RUN);

    always_comb begin
        bit_c = '0;
        for (int i = 0; i < IDIM; i++) begin
            bit_c[i] = valid_c && (data_q[i] > rng);
        end
    end

    assign bus.oBit   = bit_c;
    assign bus.oValid = valid_c;
    assign bus.busy   = (state_q != IDLE);
    assign bus.done   = (state_q == DONE);

endmodule

// File: tb/tb_buffer_bitstream_gen.sv
// Directed self-checking bench for buffer_bitstream_gen (IWID=8, IDIM=4).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_buffer_bitstream_gen;

    localparam int IWID = 8;
    localparam int IDIM = 4;

    logic clk;
    logic rst_n;

    buffer_bitstream_gen_if #(.IWID(IWID), .IDIM(IDIM)) bus ();

    buffer_bitstream_gen #(.IWID(IWID), .IDIM(IDIM)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks;
    int errors;

    // results of the last run() call
    int              vcnt;
    int              dcnt;
    int              done_at;
    int              first_v;
    int              lcnt [IDIM];
    logic [IDIM-1:0] blog [256];
    logic            chain;
    logic [IDIM-1:0][IWID-1:0] chain_data;

    task automatic accept(input logic [IDIM-1:0][IWID-1:0] d);
        @(negedge clk);
        bus.start = 1'b1;
        bus.clear = 1'b0;
        bus.iData = d;
    endtask

    // Cycle c=1 is the first cycle after the accepting edge. Inputs set
    // at cycle c are seen by the edge ending cycle c.
    task automatic run(input int p1, input int p2, input int p3,
                       input int clr_at, input bit scramble);
        bit fin;
        fin     = 1'b0;
        vcnt    = 0;
        dcnt    = 0;
        done_at = 0;
        first_v = 0;
        for (int i = 0; i < IDIM; i++) lcnt[i] = 0;
        for (int c = 1; c < 600; c++) begin
            @(negedge clk);
            if (bus.oValid) begin
                if (vcnt == 0) first_v = c;
                if (vcnt < 256) blog[vcnt] = bus.oBit;
                for (int i = 0; i < IDIM; i++) lcnt[i] += int'(bus.oBit[i]);
                vcnt++;
            end
            if (bus.done) begin
                dcnt++;
                done_at = c;
            end
            if (!bus.busy) begin
                bus.start = chain;
                bus.clear = 1'b0;
                if (chain) bus.iData = chain_data;
                fin = 1'b1;
                break;
            end
            bus.start = (c == p1) || (c == p2) || (c == p3);
            bus.clear = (c == clr_at);
            if (scramble) bus.iData = {$urandom, $urandom};
        end
        if (!fin) begin
            checks++;
            errors++;
            $display("FAIL run_timeout busy still %b after 600 cycles", bus.busy);
        end
    endtask

    task automatic test_reset;
        rst_n     = 1'b0;
        bus.start = 1'b1;
        bus.clear = 1'b0;
        bus.iData = {8'd10, 8'd1, 8'd8, 8'd9};
        chain     = 1'b0;
        chain_data = '0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if ({bus.oBit, bus.oValid, bus.busy, bus.done} !== 7'd0) begin
                errors++;
                $display("FAIL reset_outputs got %b want 0",
                         {bus.oBit, bus.oValid, bus.busy, bus.done});
            end
        end
        rst_n     = 1'b1;
        bus.start = 1'b0;
    endtask

    task automatic test_basic;
        accept({8'd10, 8'd1, 8'd8, 8'd9});
        run(0, 0, 0, 0, 1'b0);
        checks++;
        if (first_v !== 1) begin
            errors++;
            $display("FAIL basic_latency got %0d want 1", first_v);
        end
        checks++;
        if (vcnt !== 256) begin
            errors++;
            $display("FAIL basic_valid_len got %0d want 256", vcnt);
        end
        checks++;
        if (dcnt !== 1 || done_at !== 257) begin
            errors++;
            $display("FAIL basic_done got n=%0d at %0d want n=1 at 257",
                     dcnt, done_at);
        end
        checks++;
        if (lcnt[3] !== 10 || lcnt[2] !== 1 || lcnt[1] !== 8 || lcnt[0] !== 9) begin
            errors++;
            $display("FAIL basic_counts got %0d %0d %0d %0d want 10 1 8 9",
                     lcnt[3], lcnt[2], lcnt[1], lcnt[0]);
        end
        // value 1 is only above rng=0, i.e. cnt=0: proves the run began at 0
        checks++;
        if (blog[0][2] !== 1'b1) begin
            errors++;
            $display("FAIL basic_cnt0 got %b want 1", blog[0][2]);
        end
    endtask

    task automatic test_exact_counts;
        int bad128;
        int bad64;
        int bad255;
        bad128 = 0;
        bad64  = 0;
        bad255 = 0;
        accept({8'd0, 8'd255, 8'd128, 8'd64});
        run(0, 0, 0, 0, 1'b0);
        checks++;
        if (lcnt[3] !== 0 || lcnt[2] !== 255 || lcnt[1] !== 128 || lcnt[0] !== 64) begin
            errors++;
            $display("FAIL exact_counts got %0d %0d %0d %0d want 0 255 128 64",
                     lcnt[3], lcnt[2], lcnt[1], lcnt[0]);
        end
        for (int n = 0; n < 256; n++) begin
            if (blog[n][1] !== ((n % 2) == 0)) bad128++;
            if (blog[n][0] !== ((n % 4) == 0)) bad64++;
            if (blog[n][2] !== (n != 255)) bad255++;
        end
        checks++;
        if (bad128 !== 0) begin
            errors++;
            $display("FAIL pattern_128 got %0d wrong cycles want 0", bad128);
        end
        checks++;
        if (bad64 !== 0) begin
            errors++;
            $display("FAIL pattern_64 got %0d wrong cycles want 0", bad64);
        end
        checks++;
        if (bad255 !== 0) begin
            errors++;
            $display("FAIL pattern_255 got %0d wrong cycles want 0", bad255);
        end
    endtask

    task automatic test_isolation;
        accept({8'd10, 8'd2, 8'd8, 8'd9});
        run(0, 0, 0, 0, 1'b1);
        checks++;
        if (lcnt[3] !== 10 || lcnt[2] !== 2 || lcnt[1] !== 8 || lcnt[0] !== 9) begin
            errors++;
            $display("FAIL isolation_counts got %0d %0d %0d %0d want 10 2 8 9",
                     lcnt[3], lcnt[2], lcnt[1], lcnt[0]);
        end
    endtask

    task automatic test_start_busy;
        accept({8'd3, 8'd1, 8'd200, 8'd77});
        // run cycles 5 and 255 are c=6 and c=256; DONE is c=257
        run(6, 256, 257, 0, 1'b0);
        checks++;
        if (vcnt !== 256 || dcnt !== 1) begin
            errors++;
            $display("FAIL busy_start got valid=%0d done=%0d want 256 1",
                     vcnt, dcnt);
        end
        checks++;
        if (lcnt[1] !== 200 || lcnt[0] !== 77) begin
            errors++;
            $display("FAIL busy_counts got %0d %0d want 200 77", lcnt[1], lcnt[0]);
        end
        accept({8'd0, 8'd1, 8'd0, 8'd0});
        run(0, 0, 0, 0, 1'b0);
        checks++;
        if (first_v !== 1 || blog[0][2] !== 1'b1 || lcnt[2] !== 1) begin
            errors++;
            $display("FAIL restart_cnt0 got first=%0d bit0=%b n=%0d want 1 1 1",
                     first_v, blog[0][2], lcnt[2]);
        end
    endtask

    task automatic test_back_to_back;
        chain      = 1'b1;
        chain_data = {8'd4, 8'd5, 8'd6, 8'd7};
        accept({8'd1, 8'd2, 8'd3, 8'd4});
        run(0, 0, 0, 0, 1'b0);
        chain = 1'b0;
        checks++;
        if (done_at !== 257) begin
            errors++;
            $display("FAIL b2b_first_done got %0d want 257", done_at);
        end
        run(0, 0, 0, 0, 1'b0);
        checks++;
        if (first_v !== 1 || vcnt !== 256 || dcnt !== 1) begin
            errors++;
            $display("FAIL b2b_second got first=%0d valid=%0d done=%0d want 1 256 1",
                     first_v, vcnt, dcnt);
        end
        checks++;
        if (lcnt[3] !== 4 || lcnt[2] !== 5 || lcnt[1] !== 6 || lcnt[0] !== 7) begin
            errors++;
            $display("FAIL b2b_counts got %0d %0d %0d %0d want 4 5 6 7",
                     lcnt[3], lcnt[2], lcnt[1], lcnt[0]);
        end
    endtask

    task automatic test_abort;
        accept({8'd255, 8'd255, 8'd255, 8'd255});
        // run cycle 100 is c=101; c=102 must already be IDLE
        run(0, 0, 0, 101, 1'b0);
        checks++;
        if (vcnt !== 101 || dcnt !== 0) begin
            errors++;
            $display("FAIL abort got valid=%0d done=%0d want 101 0", vcnt, dcnt);
        end
        @(negedge clk);
        bus.start = 1'b1;
        bus.clear = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            checks++;
            if ({bus.oValid, bus.busy, bus.done} !== 3'b000) begin
                errors++;
                $display("FAIL clear_start got %b want 000",
                         {bus.oValid, bus.busy, bus.done});
            end
        end
        bus.start = 1'b0;
        bus.clear = 1'b0;
    endtask

    task automatic test_async_reset;
        int dseen;
        int bseen;
        dseen = 0;
        bseen = 0;
        accept({8'd255, 8'd255, 8'd255, 8'd255});
        @(negedge clk);
        bus.start = 1'b0;
        for (int k = 0; k < 49; k++) @(negedge clk);
        checks++;
        if (bus.oValid !== 1'b1 || bus.oBit !== 4'hF) begin
            errors++;
            $display("FAIL async_prerun got v=%b bits=%b want 1 1111",
                     bus.oValid, bus.oBit);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.oBit, bus.oValid, bus.busy, bus.done} !== 7'd0) begin
            errors++;
            $display("FAIL async_immediate got %b want 0",
                     {bus.oBit, bus.oValid, bus.busy, bus.done});
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            dseen += int'(bus.done);
            bseen += int'(bus.busy | bus.oValid);
        end
        checks++;
        if (dseen !== 0 || bseen !== 0) begin
            errors++;
            $display("FAIL async_after got done=%0d busy=%0d want 0 0",
                     dseen, bseen);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic();
        test_exact_counts();
        test_isolation();
        test_start_busy();
        test_back_to_back();
        test_abort();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
